// File: rtl/sha256_compress.sv
// Iterative SHA-256 compression engine: one round per accepted schedule word, feed-forward add, done pulse.
// Optional `define SHA256_COMPRESS_ABORT_EN adds an abort input that drops a running block.
package sigma_functions;
  function automatic logic [31:0] upper_sigma_zero(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] upper_sigma_one(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction
endpackage

module sha256_compress #(
  parameter int NUM_ROUNDS = 64,
  parameter int CNT_W      = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [0:255] hash_in,
  input  logic [0:31]  w_word,
  input  logic         w_valid,
  output logic         w_ready,
  output logic [0:255] digest,
  output logic         done,
  output logic         busy
`ifdef SHA256_COMPRESS_ABORT_EN
  ,
  input  logic         abort
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL} state_e;

  localparam logic [CNT_W-1:0] LAST_T = CNT_W'(NUM_ROUNDS - 1);

  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  state_e           state_q, state_d;
  logic [CNT_W-1:0] t_q;
  logic [0:255]     hash_q;
  logic [0:255]     digest_q;
  logic             done_q;
  logic [31:0]      a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q;
  logic [31:0]      ch, maj, t1, t2;
  logic             accept;
  logic             abort_hit;

`ifdef SHA256_COMPRESS_ABORT_EN
  assign abort_hit = abort && (state_q != S_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  assign accept = w_valid && w_ready;
  assign ch     = (e_q & f_q) ^ (~e_q & g_q);
  assign maj    = (a_q & b_q) ^ (a_q & c_q) ^ (b_q & c_q);
  assign t1     = h_q + sigma_functions::upper_sigma_one(e_q) + ch + K_TAB[6'(t_q)] + w_word;
  assign t2     = sigma_functions::upper_sigma_zero(a_q) + maj;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_ROUND;
      S_ROUND: if (w_valid && t_q == LAST_T) state_d = S_FINAL;
      S_FINAL: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_hit) state_d = S_IDLE;
  end

  // w_ready depends on state only, so there is no w_valid -> w_ready path
  always_comb begin
    w_ready = (state_q == S_ROUND);
    busy    = (state_q != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t_q      <= '0;
      hash_q   <= '0;
      digest_q <= '0;
      done_q   <= 1'b0;
      {a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q} <= '0;
    end else begin
      done_q <= 1'b0;
      if (abort_hit) begin
        t_q <= '0;
      end else begin
        case (state_q)
          S_IDLE: if (start) begin
            hash_q <= hash_in;
            t_q    <= '0;
            {a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q} <= hash_in;
          end
          S_ROUND: if (accept) begin
            h_q <= g_q;
            g_q <= f_q;
            f_q <= e_q;
            e_q <= d_q + t1;
            d_q <= c_q;
            c_q <= b_q;
            b_q <= a_q;
            a_q <= t1 + t2;
            t_q <= t_q + 1'b1;
          end
          S_FINAL: begin
            digest_q <= {hash_q[0+:32]   + a_q, hash_q[32+:32]  + b_q,
                         hash_q[64+:32]  + c_q, hash_q[96+:32]  + d_q,
                         hash_q[128+:32] + e_q, hash_q[160+:32] + f_q,
                         hash_q[192+:32] + g_q, hash_q[224+:32] + h_q};
            done_q   <= 1'b1;
            t_q      <= '0;
          end
          default: t_q <= '0;
        endcase
      end
    end
  end

  assign digest = digest_q;
  assign done   = done_q;

endmodule

// File: tb/tb_sha256_compress.sv
// Directed bench for sha256_compress: known "abc" and "" digests, stalls, ignored start,
// back-to-back chaining, mid-block reset and (with SHA256_COMPRESS_ABORT_EN) abort.
module tb_sha256_compress;

  localparam logic [255:0] IV      = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         clk;
  logic         rst;
  logic         start;
  logic [255:0] hash_in;
  logic [31:0]  w_word;
  logic         w_valid;
  logic         w_ready;
  logic [255:0] digest;
  logic         done;
  logic         busy;
`ifdef SHA256_COMPRESS_ABORT_EN
  logic         abort;
`endif

  logic [31:0] w_abc [64];
  logic [31:0] w_emp [64];
  int n_chk;
  int n_bad;

  sha256_compress dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .hash_in (hash_in),
    .w_word  (w_word),
    .w_valid (w_valid),
    .w_ready (w_ready),
    .digest  (digest),
    .done    (done),
    .busy    (busy)
`ifdef SHA256_COMPRESS_ABORT_EN
    ,
    .abort   (abort)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] wsel_word(input int wsel, input int i);
    return (wsel == 0) ? w_abc[i] : w_emp[i];
  endfunction

  task automatic build_schedules();
    for (int i = 0; i < 16; i++) begin
      w_abc[i] = 32'h0;
      w_emp[i] = 32'h0;
    end
    w_abc[0]  = 32'h61626380;
    w_abc[15] = 32'h00000018;
    w_emp[0]  = 32'h80000000;
    for (int i = 16; i < 64; i++) begin
      w_abc[i] = (rotr(w_abc[i-2], 17) ^ rotr(w_abc[i-2], 19) ^ (w_abc[i-2] >> 10)) + w_abc[i-7]
               + (rotr(w_abc[i-15], 7) ^ rotr(w_abc[i-15], 18) ^ (w_abc[i-15] >> 3)) + w_abc[i-16];
      w_emp[i] = (rotr(w_emp[i-2], 17) ^ rotr(w_emp[i-2], 19) ^ (w_emp[i-2] >> 10)) + w_emp[i-7]
               + (rotr(w_emp[i-15], 7) ^ rotr(w_emp[i-15], 18) ^ (w_emp[i-15] >> 3)) + w_emp[i-16];
    end
  endtask

  // Reference compression, used only where no published digest exists (chained second block)
  function automatic logic [255:0] ref_compress(input logic [255:0] hv, input int wsel);
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    logic [255:0] r;
    for (int i = 0; i < 8; i++) v[i] = hv[255-32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6]))
         + KT[t] + wsel_word(wsel, t);
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hv[255-32*i -: 32] + v[i];
    return r;
  endfunction

  // ev_kind: 0 none, 1 extra start at round ev_round, 2 rst at round ev_round, 3 abort at round ev_round
  task automatic run_block(input logic [255:0] hv, input int wsel, input bit gaps,
                           input int ev_kind, input int ev_round,
                           output logic [255:0] dg, output int lat, output int nstall,
                           output int ndone, output int busy_err);
    int  idx;
    bit  acc;
    bit  got;
    bit  injected;
    idx = 0; lat = 0; nstall = 0; ndone = 0; busy_err = 0; got = 0; injected = 0;
    hash_in = hv; start = 1'b1; w_valid = 1'b0; w_word = 32'h0;
    while (!got && lat < 400) begin
      acc = w_valid && w_ready;
      if (w_ready && !w_valid) nstall++;
      @(posedge clk); #1;
      lat++;
      start   = 1'b0;
      hash_in = ~hv;
      if (acc) idx++;
      if (done) begin
        got = 1;
        ndone++;
      end else if (!busy) begin
        busy_err++;
      end
      if (ev_kind == 1 && idx == ev_round && !injected) begin
        injected = 1;
        start    = 1'b1;
        hash_in  = {8{$urandom()}};
      end
      if (ev_kind >= 2 && idx == ev_round) begin
        w_valid = 1'b0;
        if (ev_kind == 2) rst = 1'b1;
`ifdef SHA256_COMPRESS_ABORT_EN
        if (ev_kind == 3) abort = 1'b1;
`endif
        @(posedge clk); #1;
        rst = 1'b0;
`ifdef SHA256_COMPRESS_ABORT_EN
        abort = 1'b0;
`endif
        dg = digest;
        return;
      end
      w_valid = (idx < 64) && (!gaps || $urandom_range(0, 3) != 0);
      w_word  = (idx < 64) ? wsel_word(wsel, idx) : 32'h0;
    end
    w_valid = 1'b0;
    dg = digest;
  endtask

  initial begin
    logic [255:0] dg;
    logic [255:0] d1;
    int lat, ns, nd, be;
    clk = 1'b0; rst = 1'b1; start = 1'b0; hash_in = '0; w_word = 32'h0; w_valid = 1'b1;
`ifdef SHA256_COMPRESS_ABORT_EN
    abort = 1'b0;
`endif
    n_chk = 0; n_bad = 0;
    build_schedules();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_digest", digest, '0);
    chk("rst_done", 256'(done), '0);
    chk("rst_busy", 256'(busy), '0);
    chk("rst_wready", 256'(w_ready), '0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_wready_with_valid", 256'(w_ready), '0);
    w_valid = 1'b0;

    run_block(IV, 0, 1'b0, 0, 0, dg, lat, ns, nd, be);
    chk("abc_digest", dg, D_ABC);
    chk("abc_latency", 256'(lat), 256'(66));
    chk("abc_done_count", 256'(nd), 256'(1));
    chk("abc_busy_gaps", 256'(be), '0);
    @(posedge clk); #1;
    chk("abc_done_once", 256'(done), '0);
    chk("abc_digest_hold", digest, D_ABC);

    run_block(IV, 1, 1'b1, 0, 0, dg, lat, ns, nd, be);
    chk("empty_digest", dg, D_EMPTY);
    chk("empty_latency", 256'(lat), 256'(66 + ns));
    chk("empty_done_count", 256'(nd), 256'(1));

    @(posedge clk); #1;
    run_block(IV, 0, 1'b0, 1, 10, dg, lat, ns, nd, be);
    chk("ignored_start_digest", dg, D_ABC);
    chk("ignored_start_latency", 256'(lat), 256'(66));

    @(posedge clk); #1;
    run_block(IV, 0, 1'b0, 0, 0, d1, lat, ns, nd, be);
    chk("b2b_first_digest", d1, D_ABC);
    run_block(d1, 0, 1'b0, 0, 0, dg, lat, ns, nd, be);
    chk("b2b_second_digest", dg, ref_compress(D_ABC, 0));
    chk("b2b_second_latency", 256'(lat), 256'(66));
    chk("b2b_second_busy", 256'(be), '0);

    @(posedge clk); #1;
    run_block(IV, 0, 1'b0, 2, 30, dg, lat, ns, nd, be);
    chk("midrst_digest", digest, '0);
    chk("midrst_busy", 256'(busy), '0);
    chk("midrst_wready", 256'(w_ready), '0);
    chk("midrst_done", 256'(done), '0);
    run_block(IV, 0, 1'b0, 0, 0, dg, lat, ns, nd, be);
    chk("after_rst_digest", dg, D_ABC);

`ifdef SHA256_COMPRESS_ABORT_EN
    @(posedge clk); #1;
    d1 = digest;
    run_block(IV, 1, 1'b0, 3, 20, dg, lat, ns, nd, be);
    chk("abort_busy", 256'(busy), '0);
    chk("abort_digest_kept", digest, d1);
    nd = 0;
    for (int i = 0; i < 80; i++) begin
      if (done) nd++;
      @(posedge clk); #1;
    end
    chk("abort_no_done", 256'(nd), '0);
    run_block(IV, 0, 1'b0, 0, 0, dg, lat, ns, nd, be);
    chk("after_abort_digest", dg, D_ABC);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
